// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store stage in front of a word-only data memory with a
//               registered read port. Accepts LDR/LDRB/STR/STRB requests over
//               valid/ready, converts byte addresses to word indices, performs
//               read-modify-write for byte stores and returns a one-cycle
//               response pulse (load data or fault) to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int WORD_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    // request from execute
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_rd,
    // response to writeback
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [3:0]  resp_rd,
    output logic        resp_fault,
    // data memory port
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_read_not_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD      = 3'd1;
    localparam logic [2:0] c_ST_CAP     = 3'd2;
    localparam logic [2:0] c_ST_RMW_RD  = 3'd3;
    localparam logic [2:0] c_ST_RMW_CAP = 3'd4;
    localparam logic [2:0] c_ST_WR      = 3'd5;
    localparam logic [2:0] c_ST_RESP    = 3'd6;

    // FSM state
    logic [2:0]  r_state;
    logic [2:0]  w_nextState;
    logic [2:0]  w_firstState;

    // request decode
    logic        w_accept;
    logic        w_rangeFault;
    logic        w_alignFault;
    logic        w_fault;
    logic [31:0] w_reqWordAddr;

    // registered request fields needed after the accept edge
    logic        r_isByte;
    logic [1:0]  r_lane;
    logic [3:0]  r_rd;
    logic [7:0]  r_wbyte;

    // lane handling on the memory read data
    logic [4:0]  w_laneShift;
    logic [7:0]  w_laneByte;
    logic [31:0] w_loadResult;
    logic [31:0] w_merged;

    // next values of the registered outputs
    logic        w_memEnNxt;
    logic        w_memRnwNxt;
    logic        w_respValidNxt;
    logic [31:0] w_respDataNxt;
    logic [3:0]  w_respRdNxt;
    logic        w_respFaultNxt;
    logic [31:0] w_memAddrNxt;
    logic [31:0] w_memWdataNxt;

    // registered outputs
    logic        r_respValid;
    logic [31:0] r_respData;
    logic [3:0]  r_respRd;
    logic        r_respFault;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic        r_memEn;
    logic        r_memRnw;

    // A new request can be taken when idle or while the previous response is
    // on the bus; this gives back-to-back throughput without a bubble.
    assign req_ready = ((r_state == c_ST_IDLE) || (r_state == c_ST_RESP)) && !reset;
    assign w_accept  = req_valid && req_ready;

    // Address checks: anything above the memory size is out of range, and
    // word accesses must be word aligned. Byte accesses cannot misalign.
    assign w_rangeFault  = (req_addr[31:WORD_ADDR_BITS+2] != '0);
    assign w_alignFault  = !req_byte && (req_addr[1:0] != 2'b00);
    assign w_fault       = w_rangeFault || w_alignFault;
    assign w_reqWordAddr = {{(32-WORD_ADDR_BITS){1'b0}}, req_addr[WORD_ADDR_BITS+1:2]};

    // Little-endian lane select and merge on the word returned by memory.
    assign w_laneShift = {r_lane, 3'b000};

    // Extract the addressed lane and build the read-modify-write word
    always_comb begin
        w_laneByte              = mem_rdata[w_laneShift +: 8];
        w_loadResult            = r_isByte ? {24'h000000, w_laneByte} : mem_rdata;
        w_merged                = mem_rdata;
        w_merged[w_laneShift +: 8] = r_wbyte;
    end

    // First state of a newly accepted request
    always_comb begin
        if (w_fault) begin
            w_firstState = c_ST_RESP;
        end else if (req_load) begin
            w_firstState = c_ST_RD;
        end else if (req_byte) begin
            w_firstState = c_ST_RMW_RD;
        end else begin
            w_firstState = c_ST_WR;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RESP: w_nextState = w_accept ? w_firstState : c_ST_IDLE;
            c_ST_RD:              w_nextState = c_ST_CAP;
            c_ST_CAP:             w_nextState = c_ST_RESP;
            c_ST_RMW_RD:          w_nextState = c_ST_RMW_CAP;
            c_ST_RMW_CAP:         w_nextState = c_ST_WR;
            c_ST_WR:              w_nextState = c_ST_RESP;
            default:              w_nextState = c_ST_IDLE;
        endcase
    end

    // Output decode: outputs are registered, so derive them from the next state
    always_comb begin
        w_memEnNxt     = (w_nextState == c_ST_RD) || (w_nextState == c_ST_RMW_RD) ||
                         (w_nextState == c_ST_WR);
        w_memRnwNxt    = (w_nextState != c_ST_WR);
        w_respValidNxt = (w_nextState == c_ST_RESP);
        w_respDataNxt  = 32'h0000_0000;
        w_respRdNxt    = 4'h0;
        w_respFaultNxt = 1'b0;
        w_memAddrNxt   = r_memAddr;
        w_memWdataNxt  = r_memWdata;

        if (w_nextState == c_ST_RESP) begin
            if (w_accept) begin
                // only a faulting request goes straight from accept to RESP
                w_respRdNxt    = req_rd;
                w_respFaultNxt = 1'b1;
            end else begin
                w_respRdNxt    = r_rd;
                w_respDataNxt  = (r_state == c_ST_CAP) ? w_loadResult : 32'h0000_0000;
            end
        end

        // a faulting request leaves the memory address untouched
        if (w_accept && !w_fault) begin
            w_memAddrNxt = w_reqWordAddr;
        end

        if (w_accept && (w_nextState == c_ST_WR)) begin
            w_memWdataNxt = req_wdata;
        end else if (r_state == c_ST_RMW_CAP) begin
            w_memWdataNxt = w_merged;
        end
    end

    // Output and request-field registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_respValid <= 1'b0;
            r_respData  <= 32'h0000_0000;
            r_respRd    <= 4'h0;
            r_respFault <= 1'b0;
            r_memAddr   <= 32'h0000_0000;
            r_memWdata  <= 32'h0000_0000;
            r_memEn     <= 1'b0;
            r_memRnw    <= 1'b0;
            r_isByte    <= 1'b0;
            r_lane      <= 2'b00;
            r_rd        <= 4'h0;
            r_wbyte     <= 8'h00;
        end else begin
            r_respValid <= w_respValidNxt;
            r_respData  <= w_respDataNxt;
            r_respRd    <= w_respRdNxt;
            r_respFault <= w_respFaultNxt;
            r_memAddr   <= w_memAddrNxt;
            r_memWdata  <= w_memWdataNxt;
            r_memEn     <= w_memEnNxt;
            r_memRnw    <= w_memRnwNxt;
            if (w_accept) begin
                r_isByte <= req_byte;
                r_lane   <= req_addr[1:0];
                r_rd     <= req_rd;
                r_wbyte  <= req_wdata[7:0];
            end
        end
    end

    assign resp_valid         = r_respValid;
    assign resp_data          = r_respData;
    assign resp_rd            = r_respRd;
    assign resp_fault         = r_respFault;
    assign mem_addr           = r_memAddr;
    assign mem_wdata          = r_memWdata;
    assign mem_en             = r_memEn;
    assign mem_read_not_write = r_memRnw;

endmodule
`default_nettype wire
